park_reserve_ctrl: RTL and testbench
====================================

PARK_RESERVE_CTRL -- requirements
Module: park_reserve_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 32'd50_000_000, SPOT-state inactivity limit in clk cycles (1 s at 50 MHz).
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: city_done  input  1  level; high = upstream city selection is valid.
REQ-005 Port: city  input  2  city code: 00 NYC Downtown, 01 Toronto Downtown, 10 Waterloo, 11 invalid.
REQ-006 Port: spot  input  4  spot index 0..8 from the one-hot spot decoder; 9..15 invalid.
REQ-007 Port: confirm  input  1  level from the confirm key, synchronised upstream; a rising edge commits the request.
REQ-008 Port: release  input  1  sampled with confirm: 0 = reserve spot, 1 = free spot.
REQ-009 Port: occ_map  output  9  occupancy bits of the latched city; bit i = spot i occupied (drives LEDR).
REQ-010 Port: free_count  output  4  count of zero bits in occ_map, range 0..9.
REQ-011 Port: grant  output  1  one-cycle pulse: request accepted.
REQ-012 Port: deny  output  1  one-cycle pulse: request rejected.
REQ-013 Port: busy  output  1  high in every state except IDLE.

Function
REQ-014 Occupancy storage SHALL be 3 x 9 bits, one row per valid city; city 11 has no row.
REQ-015 The FSM SHALL have states IDLE, SPOT, CHECK, RESULT, HOLD.
REQ-016 IDLE: if city_done=1 and city!=11, latch city into cur_city and go to SPOT; if city=11, stay in IDLE.
REQ-017 SPOT: a confirm edge (confirm=1 with previous-cycle confirm=0) latches spot and release and goes to CHECK.
REQ-018 SPOT: if city_done falls before a confirm edge, go to IDLE with no grant or deny.
REQ-019 CHECK lasts exactly one cycle and applies these rules:
  - spot>8: deny.
  - Reserve of a free spot: set the bit, grant.
  - Reserve of an occupied spot: deny, no change.
  - Release of an occupied spot: clear the bit, grant.
  - Release of a free spot: deny.
REQ-020 RESULT lasts exactly one cycle, with exactly one of grant or deny high.
REQ-021 Latency: if the confirm edge is first sampled at clock edge n, grant or deny SHALL be high during cycle n+2 (after edge n+2), and occ_map SHALL show the update in the same cycle.
REQ-022 HOLD: wait until city_done=0, then go to IDLE; this prevents re-entry on a held selection.
REQ-023 A confirm that is held high SHALL produce only one request.
REQ-024 confirm edges in IDLE, CHECK, RESULT or HOLD SHALL be ignored, and SHALL NOT be queued.
REQ-025 occ_map and free_count SHALL be registered or derived from cur_city, and SHALL update within the cycle after cur_city or occupancy changes.
REQ-026 Occupancy rows other than cur_city SHALL never change.

Reset
REQ-027 When reset=1 at a clock edge, the following SHALL take effect at that edge:
  - state=IDLE, all occupancy bits=0, cur_city=00.
  - occ_map=0, free_count=9, grant=0, deny=0, busy=0.
  - Internal confirm history=0 and timeout counter=0.
REQ-028 Reset asserted mid-transaction, including in CHECK, SHALL abort it with no grant or deny and no occupancy write.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-030 Macro PARK_TIMEOUT_EN, when defined, SHALL add the timeout behaviour:
  - A counter runs in SPOT and clears on entry to SPOT and on any confirm edge.
  - When it reaches TIMEOUT_CYCLES-1 without a confirm edge, the FSM goes to HOLD with a one-cycle deny pulse.
  - The counter is at least 32 bits and SHALL NOT wrap.
REQ-031 Without PARK_TIMEOUT_EN, SPOT SHALL wait indefinitely, and no counter logic SHALL be synthesised.

Verification
REQ-032 Reset, then city_done=1, city=01, one confirm edge with spot=3, release=0 -> busy=1, grant pulse 2 cycles after the edge, occ_map=9'h008, free_count=8.
REQ-033 Repeat REQ-032 without clearing (city_done low, then high again) -> deny pulse, occ_map unchanged at 9'h008; then release=1 on spot 3 -> grant, occ_map=0, free_count=9.
REQ-034 Reserve spot 8 in city 00, then select city 10 -> occ_map=0 in city 10; reselect city 00 -> occ_map=9'h100.
REQ-035 city=11 with city_done=1 -> state stays IDLE, busy=0; spot=9 with a confirm edge -> deny, no bit changes.
REQ-036 Hold confirm high for 20 cycles in SPOT -> exactly one grant; assert reset in the CHECK cycle -> no pulse, occ_map=0.
REQ-037 With PARK_TIMEOUT_EN and TIMEOUT_CYCLES=16, stay in SPOT with no confirm -> deny at cycle 16, FSM in HOLD until city_done=0.

Source files
------------

// File: rtl/park_reserve_ctrl.sv
// rtl/park_reserve_ctrl.sv - parking reservation FSM over 3 cities x 9 spots
// Optional SPOT inactivity timeout enabled by defining PARK_TIMEOUT_EN.
module park_reserve_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       city_done,
  input  logic [1:0] city,
  input  logic [3:0] spot,
  input  logic       confirm,
  input  logic       release_sel,
  output logic [8:0] occ_map,
  output logic [3:0] free_count,
  output logic       grant,
  output logic       deny,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, SPOT, CHECK, RESULT, HOLD} state_t;

  state_t          state;
  logic [2:0][8:0] occ;
  logic [1:0]      cur_city;
  logic            conf_q;
  logic [3:0]      spot_q;
  logic            rel_q;
  logic            ok_q;

`ifdef PARK_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 32'd1;
  logic [31:0] to_cnt;
`else
  if (TIMEOUT_CYCLES == 32'd0) begin : g_timeout_unused
  end
`endif

  assign occ_map = occ[cur_city];

  always_comb begin
    free_count = 4'd0;
    for (int i = 0; i < 9; i++)
      free_count = free_count + {3'b000, ~occ_map[i]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      occ      <= '0;
      cur_city <= 2'b00;
      conf_q   <= 1'b0;
      spot_q   <= 4'd0;
      rel_q    <= 1'b0;
      ok_q     <= 1'b0;
      grant    <= 1'b0;
      deny     <= 1'b0;
      busy     <= 1'b0;
`ifdef PARK_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      conf_q <= confirm;
      grant  <= 1'b0;
      deny   <= 1'b0;
      case (state)
        IDLE: begin
          if (city_done && city != 2'b11) begin
            cur_city <= city;
            state    <= SPOT;
            busy     <= 1'b1;
`ifdef PARK_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end
        SPOT: begin
          // Losing the city selection wins over a simultaneous confirm edge.
          if (!city_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (confirm && !conf_q) begin
            spot_q <= spot;
            rel_q  <= release_sel;
            state  <= CHECK;
`ifdef PARK_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
`ifdef PARK_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            deny  <= 1'b1;
            state <= HOLD;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 32'd1;
          end
`endif
        end
        CHECK: begin
          if (spot_q > 4'd8)
            ok_q <= 1'b0;
          else
            ok_q <= rel_q ? occ[cur_city][spot_q] : ~occ[cur_city][spot_q];
          state <= RESULT;
        end
        RESULT: begin
          // The occupancy write lands with the pulse so a reset in CHECK leaves no trace.
          if (ok_q)
            occ[cur_city][spot_q] <= ~rel_q;
          grant <= ok_q;
          deny  <= ~ok_q;
          state <= HOLD;
        end
        HOLD: begin
          if (!city_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_park_reserve_ctrl.sv
// tb/tb_park_reserve_ctrl.sv - table-driven self-checking bench for park_reserve_ctrl
module tb_park_reserve_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       city_done;
  logic [1:0] city;
  logic [3:0] spot;
  logic       confirm;
  logic       release_sel;
  logic [8:0] occ_map;
  logic [3:0] free_count;
  logic       grant;
  logic       deny;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  park_reserve_ctrl #(.TIMEOUT_CYCLES(32'd16)) dut (
    .clk        (clk),
    .reset      (reset),
    .city_done  (city_done),
    .city       (city),
    .spot       (spot),
    .confirm    (confirm),
    .release_sel(release_sel),
    .occ_map    (occ_map),
    .free_count (free_count),
    .grant      (grant),
    .deny       (deny),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cd;
    logic [1:0] c;
    logic [3:0] s;
    logic       cf;
    logic       r;
    logic       b;
    logic       g;
    logic       d;
    logic [8:0] om;
    logic [3:0] fc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic cd, input logic [1:0] c, input logic [3:0] s,
                     input logic cf, input logic r, input logic b, input logic g,
                     input logic d, input logic [8:0] om, input logic [3:0] fc);
    vec_t v;
    v.cd = cd; v.c = c; v.s = s; v.cf = cf; v.r = r;
    v.b = b; v.g = g; v.d = d; v.om = om; v.fc = fc;
    tbl.push_back(v);
  endtask

  task automatic check_out(input string name, input logic b, input logic g,
                           input logic d, input logic [8:0] om, input logic [3:0] fc);
    checks++;
    if (busy !== b || grant !== g || deny !== d || occ_map !== om || free_count !== fc) begin
      fails++;
      $display("FAIL %s: got busy=%b grant=%b deny=%b occ_map=%h free_count=%0d, expected busy=%b grant=%b deny=%b occ_map=%h free_count=%0d",
               name, busy, grant, deny, occ_map, free_count, b, g, d, om, fc);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic cd, input logic [1:0] c, input logic [3:0] s,
                       input logic cf, input logic r);
    city_done = cd; city = c; spot = s; confirm = cf; release_sel = r;
  endtask

  initial begin
    int pulses;
    int denies;

    //   cd  c      s     cf    r     busy  g     d     occ      fc
    add(1, 2'b01, 4'd3, 0, 0, 1, 0, 0, 9'h000, 4'd9);  // reserve city 01 spot 3
    add(1, 2'b01, 4'd3, 1, 0, 1, 0, 0, 9'h000, 4'd9);
    add(1, 2'b01, 4'd3, 0, 0, 1, 0, 0, 9'h000, 4'd9);
    add(1, 2'b01, 4'd3, 0, 0, 1, 1, 0, 9'h008, 4'd8);
    add(1, 2'b01, 4'd3, 0, 0, 1, 0, 0, 9'h008, 4'd8);
    add(0, 2'b01, 4'd3, 0, 0, 0, 0, 0, 9'h008, 4'd8);
    add(1, 2'b01, 4'd3, 0, 0, 1, 0, 0, 9'h008, 4'd8);  // repeat -> deny
    add(1, 2'b01, 4'd3, 1, 0, 1, 0, 0, 9'h008, 4'd8);
    add(1, 2'b01, 4'd3, 0, 0, 1, 0, 0, 9'h008, 4'd8);
    add(1, 2'b01, 4'd3, 0, 0, 1, 0, 1, 9'h008, 4'd8);
    add(0, 2'b01, 4'd3, 0, 0, 0, 0, 0, 9'h008, 4'd8);
    add(1, 2'b01, 4'd3, 0, 1, 1, 0, 0, 9'h008, 4'd8);  // release spot 3
    add(1, 2'b01, 4'd3, 1, 1, 1, 0, 0, 9'h008, 4'd8);
    add(1, 2'b01, 4'd3, 0, 1, 1, 0, 0, 9'h008, 4'd8);
    add(1, 2'b01, 4'd3, 0, 1, 1, 1, 0, 9'h000, 4'd9);
    add(0, 2'b01, 4'd3, 0, 1, 0, 0, 0, 9'h000, 4'd9);
    add(1, 2'b00, 4'd8, 0, 0, 1, 0, 0, 9'h000, 4'd9);  // reserve city 00 spot 8
    add(1, 2'b00, 4'd8, 1, 0, 1, 0, 0, 9'h000, 4'd9);
    add(1, 2'b00, 4'd8, 0, 0, 1, 0, 0, 9'h000, 4'd9);
    add(1, 2'b00, 4'd8, 0, 0, 1, 1, 0, 9'h100, 4'd8);
    add(0, 2'b00, 4'd8, 0, 0, 0, 0, 0, 9'h100, 4'd8);
    add(1, 2'b10, 4'd8, 0, 0, 1, 0, 0, 9'h000, 4'd9);  // city 10 row is empty
    add(0, 2'b10, 4'd8, 0, 0, 0, 0, 0, 9'h000, 4'd9);
    add(1, 2'b00, 4'd8, 0, 0, 1, 0, 0, 9'h100, 4'd8);
    add(0, 2'b00, 4'd8, 0, 0, 0, 0, 0, 9'h100, 4'd8);
    add(1, 2'b11, 4'd0, 0, 0, 0, 0, 0, 9'h100, 4'd8);  // invalid city stays idle
    add(1, 2'b11, 4'd0, 0, 0, 0, 0, 0, 9'h100, 4'd8);
    add(0, 2'b11, 4'd0, 0, 0, 0, 0, 0, 9'h100, 4'd8);
    add(1, 2'b00, 4'd9, 0, 0, 1, 0, 0, 9'h100, 4'd8);  // spot 9 -> deny
    add(1, 2'b00, 4'd9, 1, 0, 1, 0, 0, 9'h100, 4'd8);
    add(1, 2'b00, 4'd9, 0, 0, 1, 0, 0, 9'h100, 4'd8);
    add(1, 2'b00, 4'd9, 0, 0, 1, 0, 1, 9'h100, 4'd8);
    add(0, 2'b00, 4'd9, 0, 0, 0, 0, 0, 9'h100, 4'd8);
    add(0, 2'b00, 4'd0, 1, 0, 0, 0, 0, 9'h100, 4'd8);  // confirm edge in IDLE ignored
    add(1, 2'b00, 4'd0, 1, 0, 1, 0, 0, 9'h100, 4'd8);
    add(1, 2'b00, 4'd0, 1, 0, 1, 0, 0, 9'h100, 4'd8);
    add(0, 2'b00, 4'd0, 0, 0, 0, 0, 0, 9'h100, 4'd8);  // abort SPOT, no pulse

    reset = 1'b1;
    drive(0, 2'b00, 4'd0, 0, 0);
    @(posedge clk);
    step();
    check_out("reset", 0, 0, 0, 9'h000, 4'd9);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cd, tbl[i].c, tbl[i].s, tbl[i].cf, tbl[i].r);
      step();
      check_out($sformatf("row%0d", i), tbl[i].b, tbl[i].g, tbl[i].d, tbl[i].om, tbl[i].fc);
    end

    // Held confirm must yield a single request.
    reset = 1'b1;
    drive(0, 2'b00, 4'd0, 0, 0);
    step();
    reset = 1'b0;
    drive(1, 2'b01, 4'd5, 0, 0);
    step();
    pulses = 0;
    denies = 0;
    confirm = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (grant) pulses++;
      if (deny) denies++;
    end
    check_val("held_confirm_grants", pulses, 1);
    check_val("held_confirm_denies", denies, 0);
    check_out("held_confirm_state", 1, 0, 0, 9'h020, 4'd8);
    drive(0, 2'b01, 4'd5, 0, 0);
    step();

    // Reset while in CHECK aborts with no pulse.
    drive(1, 2'b01, 4'd2, 0, 0);
    step();
    confirm = 1'b1;
    step();
    reset = 1'b1;
    drive(0, 2'b01, 4'd2, 0, 0);
    step();
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (grant || deny) pulses++;
    end
    check_val("reset_in_check_pulses", pulses, 0);
    check_out("reset_in_check_state", 0, 0, 0, 9'h000, 4'd9);

`ifdef PARK_TIMEOUT_EN
    begin
      int deny_at;
      deny_at = -1;
      drive(1, 2'b10, 4'd0, 0, 0);
      step();
      for (int k = 1; k <= 24; k++) begin
        step();
        if (deny && deny_at < 0) deny_at = k;
      end
      check_val("timeout_deny_cycle", deny_at, 16);
      check_out("timeout_hold", 1, 0, 0, 9'h000, 4'd9);
      city_done = 1'b0;
      step();
      check_out("timeout_release", 0, 0, 0, 9'h000, 4'd9);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
